delay_tap_line: RTL and testbench

- 4-bit programmable delay line: input sample `a` is shifted through a 4-stage register chain every clock.
- Output `y` is taken from the tap chosen by {sel_1, sel}, giving 1 to 4 cycles of delay.
- Used as a sample-alignment element in datapaths.
- Data is opaque bits: two's-complement values pass unchanged.

---
 rtl/delay_tap_line.sv | 97 +++++++++
 tb/tb_delay_tap_line.sv | 139 +++++++++++++
 2 files changed

// File: rtl/delay_tap_line.sv
// -----------------------------------------------------------------------------
// delay_tap_line
//
// Programmable sample-alignment delay line. The input sample is shifted through
// a DEPTH-stage register chain on every rising clock edge, and the output is
// taken from the stage chosen by the 2-bit tap select {sel_1, sel}. Data is
// treated as opaque bits, so two's-complement values pass through unchanged.
//
// Configuration macro:
//   DELAY_TAP_OUT_REG_EN  - when defined, y is driven from an output register
//                           (latency s+2, glitch-free). When undefined, y is a
//                           combinational mux of the stage registers
//                           (latency s+1).
//
// Parameters:
//   WIDTH  sample width in bits (a, y and every stage)
//   DEPTH  number of stages; must be 4 to match the 2-bit tap select
//
// Ports:
//   clk    in   1      rising-edge clock
//   clear  in   1      synchronous active-low clear of all state
//   a      in   WIDTH  input sample, captured every edge while clear=1
//   sel    in   1      tap select LSB
//   sel_1  in   1      tap select MSB
//   y      out  WIDTH  delayed sample from the selected tap
// -----------------------------------------------------------------------------
module delay_tap_line #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] a,
   input  logic             sel,
   input  logic             sel_1,
   output logic [WIDTH-1:0] y
);

   // The tap select is exactly two bits wide, so only a 4-stage chain is
   // addressable without holes or unreachable stages.
   generate
      if (DEPTH != 4) begin : g_bad_depth
         $error("delay_tap_line: DEPTH must be 4 (2-bit tap select), got %0d", DEPTH);
      end
   endgenerate

   logic [WIDTH-1:0] r_st [DEPTH];
   logic [1:0]       w_tap;
   logic [WIDTH-1:0] w_tap_data;

   assign w_tap = {sel_1, sel};

   // Shift chain. Clear has priority over capture; the incoming sample on a
   // clearing edge is dropped.
   always_ff @(posedge clk) begin
      if (!clear) begin
         // NOTE: every stage is cleared, not just the head, so a flush never
         // lets a pre-clear sample reappear at a deep tap.
         for (int k = 0; k < DEPTH; k++) begin
            r_st[k] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments make every stage read its
         // neighbour's pre-edge value, which is what turns this into a shift.
         r_st[0] <= a;
         for (int k = 1; k < DEPTH; k++) begin
            r_st[k] <= r_st[k-1];
         end
      end
   end

   // Tap mux over register outputs only; a never reaches y combinationally.
   always_comb begin
      // NOTE: default first so no path through this block can infer a latch.
      w_tap_data = '0;
      w_tap_data = r_st[w_tap];
   end

`ifdef DELAY_TAP_OUT_REG_EN
   // Registered output: samples the pre-edge stage selected by the tap, so a
   // tap change is visible on y only after the following edge.
   logic [WIDTH-1:0] r_y;

   always_ff @(posedge clk) begin
      if (!clear) begin
         r_y <= '0;
      end else begin
         r_y <= w_tap_data;
      end
   end

   assign y = r_y;
`else
   assign y = w_tap_data;
`endif

endmodule

// File: tb/tb_delay_tap_line.sv
`timescale 1ns/1ps
module tb_delay_tap_line;

   localparam int WIDTH = 4;
`ifdef DELAY_TAP_OUT_REG_EN
   localparam bit REG_OUT = 1'b1;
`else
   localparam bit REG_OUT = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             clear;
   logic [WIDTH-1:0] a;
   logic             sel;
   logic             sel_1;
   logic [WIDTH-1:0] y;

   delay_tap_line #(.WIDTH(WIDTH), .DEPTH(4)) dut (
      .clk   (clk),
      .clear (clear),
      .a     (a),
      .sel   (sel),
      .sel_1 (sel_1),
      .y     (y)
   );

   always #10 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      logic             clear;
      logic [WIDTH-1:0] a;
      logic [1:0]       s;
      logic [WIDTH-1:0] exp_base;  // expected y, combinational tap build
      logic [WIDTH-1:0] exp_reg;   // expected y, registered output build
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: y=%b expected %b", name, act, exp);
      end
   endtask

   // Drive inputs away from the edge, let one rising edge happen, sample y.
   task automatic step(input logic c, input logic [WIDTH-1:0] av, input logic [1:0] s,
                       input logic [WIDTH-1:0] eb, input logic [WIDTH-1:0] er,
                       input string name);
      @(negedge clk);
      clear        = c;
      a            = av;
      {sel_1, sel} = s;
      @(posedge clk);
      #1;
      check(name, y, REG_OUT ? er : eb);
   endtask

   // Change the tap between edges and sample y without a clock edge.
   task automatic set_tap(input logic [1:0] s, input logic [WIDTH-1:0] eb,
                          input logic [WIDTH-1:0] er, input string name);
      {sel_1, sel} = s;
      #1;
      check(name, y, REG_OUT ? er : eb);
   endtask

   initial begin
      // Reset with a=7 on each tap combination.
      vecs[0]  = '{1'b0, 4'd7,  2'd0, 4'd0,  4'd0};
      vecs[1]  = '{1'b0, 4'd7,  2'd1, 4'd0,  4'd0};
      vecs[2]  = '{1'b0, 4'd7,  2'd2, 4'd0,  4'd0};
      vecs[3]  = '{1'b0, 4'd7,  2'd3, 4'd0,  4'd0};
      // Delay 1 (s=0).
      vecs[4]  = '{1'b1, 4'd7,  2'd0, 4'd7,  4'd0};
      vecs[5]  = '{1'b1, 4'd10, 2'd0, 4'd10, 4'd7};
      vecs[6]  = '{1'b1, 4'd3,  2'd0, 4'd3,  4'd10};
      vecs[7]  = '{1'b1, 4'd12, 2'd0, 4'd12, 4'd3};
      // Flush, then delay 4 (s=3) of a single 5.
      vecs[8]  = '{1'b0, 4'd5,  2'd3, 4'd0,  4'd0};
      vecs[9]  = '{1'b1, 4'd5,  2'd3, 4'd0,  4'd0};
      vecs[10] = '{1'b1, 4'd0,  2'd3, 4'd0,  4'd0};
      vecs[11] = '{1'b1, 4'd0,  2'd3, 4'd0,  4'd0};
      vecs[12] = '{1'b1, 4'd0,  2'd3, 4'd5,  4'd0};
      vecs[13] = '{1'b1, 4'd0,  2'd3, 4'd0,  4'd5};
      vecs[14] = '{1'b1, 4'd0,  2'd3, 4'd0,  4'd0};
      // Signed sample -4 passes bit-exactly.
      vecs[15] = '{1'b1, 4'b1100, 2'd0, 4'b1100, 4'd0};
      vecs[16] = '{1'b1, 4'd0,    2'd0, 4'd0,    4'b1100};

      clear = 1'b0;
      a     = '0;
      sel   = 1'b0;
      sel_1 = 1'b0;

      for (int i = 0; i < 17; i++) begin
         step(vecs[i].clear, vecs[i].a, vecs[i].s, vecs[i].exp_base,
              vecs[i].exp_reg, $sformatf("vec%0d", i));
      end

      // Chain now holds [0,12,0,0]; load 1,2,3,4 at tap 0.
      step(1'b1, 4'd1, 2'd0, 4'd1, 4'd0, "load1");
      step(1'b1, 4'd2, 2'd0, 4'd2, 4'd1, "load2");
      step(1'b1, 4'd3, 2'd0, 4'd3, 4'd2, "load3");
      step(1'b1, 4'd4, 2'd0, 4'd4, 4'd3, "load4");

      // Chain holds [4,3,2,1]. Sweep taps with no clock edge: the mux build
      // follows the select immediately, the registered build holds 3.
      set_tap(2'd0, 4'd4, 4'd3, "sweep_s0");
      set_tap(2'd1, 4'd3, 4'd3, "sweep_s1");
      set_tap(2'd2, 4'd2, 4'd3, "sweep_s2");
      set_tap(2'd3, 4'd1, 4'd3, "sweep_s3");

      // Mid-stream flush: one clearing edge empties every stage.
      step(1'b0, 4'd6, 2'd0, 4'd0, 4'd0, "flush_s0");
      set_tap(2'd1, 4'd0, 4'd0, "flush_s1");
      set_tap(2'd2, 4'd0, 4'd0, "flush_s2");
      set_tap(2'd3, 4'd0, 4'd0, "flush_s3");

      // Refill with 9; deeper taps must not show pre-flush data.
      step(1'b1, 4'd9, 2'd0, 4'd9, 4'd0, "refill_s0");
      set_tap(2'd1, 4'd0, 4'd0, "refill_s1");
      step(1'b1, 4'd0, 2'd0, 4'd0, 4'd9, "after9_s0");
      step(1'b1, 4'd0, 2'd1, 4'd0, 4'd9, "after9_s1");
      step(1'b1, 4'd0, 2'd3, 4'd9, 4'd0, "after9_s3");

      // Held clear: stages stay zero for several edges.
      step(1'b0, 4'd15, 2'd3, 4'd0, 4'd0, "hold_clr1");
      step(1'b0, 4'd15, 2'd0, 4'd0, 4'd0, "hold_clr2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
